rc4_key_search: RTL and testbench

RC4_KEY_SEARCH -- requirements
Module: rc4_key_search

---
 rtl/rc4_pkg.sv | 20 ++
 rtl/rc4_char_check.sv | 13 +
 rtl/rc4_key_search.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_rc4_key_search.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search block: FSM states,
// printable-character bounds and the S-box size.
package rc4_pkg;

    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam int         SBOX_SIZE  = 256;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA,
        PRGA,
        CHECK,
        NEXT_KEY,
        DONE
    } rc4_state_e;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext classifier: a byte is acceptable if it is a
// lower-case letter or a space.
module rc4_char_check
    import rc4_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       valid
);

    assign valid = ((byte_in >= CHAR_LO) && (byte_in <= CHAR_HI)) ||
                   (byte_in == CHAR_SPACE);

endmodule

// File: rtl/rc4_key_search.sv
// Brute-force RC4 key search over [key_first, key_last] using an external
// S-box RAM, ciphertext ROM and plaintext RAM. Optional macro: RC4_EARLY_ABORT_EN.
module rc4_key_search
    import rc4_pkg::*;
#(
    parameter int  KEY_BITS   = 24,
    parameter int  MSG_LEN    = 32,
    parameter int  KEY_STRIDE = 1,
    localparam int AW         = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_first,
    input  logic [KEY_BITS-1:0] key_last,
    output logic                busy,
    output logic                found,
    output logic                not_found,
    output logic [KEY_BITS-1:0] display_key,
    output logic [7:0]          s_address,
    output logic [7:0]          s_data,
    output logic                s_wren,
    input  logic [7:0]          s_q,
    output logic [AW-1:0]       rom_address,
    input  logic [7:0]          rom_q,
    output logic [AW-1:0]       decrypt_address,
    output logic [7:0]          decrypt_data,
    output logic                decrypt_wren,
    input  logic [7:0]          decrypt_q
);

    localparam int KEY_BYTES = KEY_BITS / 8;
    localparam int KW1       = KEY_BITS + 1;

    rc4_state_e          state_q, state_d;
    logic [3:0]          phase_q, phase_d;
    logic [7:0]          i_q, i_d;
    logic [7:0]          j_q, j_d;
    logic [8:0]          k_q, k_d;
    logic [2:0]          kidx_q, kidx_d;
    logic [7:0]          si_q, si_d;
    logic [7:0]          sj_q, sj_d;
    logic [7:0]          rom_byte_q, rom_byte_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [KEY_BITS-1:0] key_last_q, key_last_d;
    logic                busy_q, busy_d;
    logic                found_q, found_d;
    logic                not_found_q, not_found_d;
    logic [7:0]          s_address_q, s_address_d;
    logic [7:0]          s_data_q, s_data_d;
    logic                s_wren_q, s_wren_d;
    logic [AW-1:0]       rom_address_q, rom_address_d;
    logic [AW-1:0]       decrypt_address_q, decrypt_address_d;
    logic [7:0]          decrypt_data_q, decrypt_data_d;
    logic                decrypt_wren_q, decrypt_wren_d;

    logic [7:0]   key_byte;
    logic [7:0]   i_inc;
    logic [7:0]   j_ksa;
    logic [7:0]   j_prga;
    logic [7:0]   sum_idx;
    logic [7:0]   decrypted;
    logic [7:0]   check_byte;
    logic         byte_valid;
    logic [KW1-1:0] key_next;
    logic         key_over;
    logic         last_byte;

    // Key byte 0 is the most significant byte of the key under test.
    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == 3'(b)) begin
                key_byte = key_q[KEY_BITS-1-8*b -: 8];
            end
        end
    end

    assign i_inc      = i_q + 8'd1;
    assign j_ksa      = j_q + s_q + key_byte;
    assign j_prga     = j_q + s_q;
    assign sum_idx    = si_q + sj_q;
    assign decrypted  = s_q ^ rom_byte_q;
    assign check_byte = (state_q == CHECK) ? decrypt_q : decrypted;
    assign last_byte  = (k_q == 9'(MSG_LEN - 1));

    // Extra top bit catches overflow so the search never wraps to zero.
    assign key_next = {1'b0, key_q} + KW1'(KEY_STRIDE);
    assign key_over = key_next[KEY_BITS] || (key_next[KEY_BITS-1:0] > key_last_q);

    rc4_char_check u_char_check (
        .byte_in (check_byte),
        .valid   (byte_valid)
    );

    always_comb begin
        state_d           = state_q;
        phase_d           = phase_q;
        i_d               = i_q;
        j_d               = j_q;
        k_d               = k_q;
        kidx_d            = kidx_q;
        si_d              = si_q;
        sj_d              = sj_q;
        rom_byte_d        = rom_byte_q;
        key_d             = key_q;
        key_last_d        = key_last_q;
        busy_d            = busy_q;
        found_d           = found_q;
        not_found_d       = not_found_q;
        s_address_d       = s_address_q;
        s_data_d          = s_data_q;
        s_wren_d          = 1'b0;
        rom_address_d     = rom_address_q;
        decrypt_address_d = decrypt_address_q;
        decrypt_data_d    = decrypt_data_q;
        decrypt_wren_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    key_d       = key_first;
                    key_last_d  = key_last;
                    found_d     = 1'b0;
                    not_found_d = 1'b0;
                    busy_d      = 1'b1;
                    i_d         = '0;
                    j_d         = '0;
                    k_d         = '0;
                    kidx_d      = '0;
                    phase_d     = '0;
                    state_d     = INIT;
                end
            end

            INIT: begin
                s_address_d = i_q;
                s_data_d    = i_q;
                s_wren_d    = 1'b1;
                i_d         = i_inc;
                if (i_q == 8'(SBOX_SIZE - 1)) begin
                    j_d     = '0;
                    kidx_d  = '0;
                    phase_d = '0;
                    state_d = KSA;
                end
            end

            // Each step: read s[i], read s[j], write both halves of the swap.
            KSA: begin
                phase_d = phase_q + 4'd1;
                case (phase_q)
                    4'd0: s_address_d = i_q;
                    4'd2: begin
                        si_d        = s_q;
                        j_d         = j_ksa;
                        s_address_d = j_ksa;
                    end
                    4'd4: begin
                        s_address_d = i_q;
                        s_data_d    = s_q;
                        s_wren_d    = 1'b1;
                    end
                    4'd5: begin
                        s_address_d = j_q;
                        s_data_d    = si_q;
                        s_wren_d    = 1'b1;
                        i_d         = i_inc;
                        kidx_d      = (kidx_q == 3'(KEY_BYTES - 1)) ? 3'd0 : kidx_q + 3'd1;
                        phase_d     = '0;
                        if (i_q == 8'(SBOX_SIZE - 1)) begin
                            i_d     = '0;
                            j_d     = '0;
                            k_d     = '0;
                            state_d = PRGA;
                        end
                    end
                    default: ;
                endcase
            end

            PRGA: begin
                phase_d = phase_q + 4'd1;
                case (phase_q)
                    4'd0: begin
                        i_d           = i_inc;
                        s_address_d   = i_inc;
                        rom_address_d = k_q[AW-1:0];
                    end
                    4'd2: begin
                        si_d        = s_q;
                        j_d         = j_prga;
                        s_address_d = j_prga;
                        rom_byte_d  = rom_q;
                    end
                    4'd4: begin
                        sj_d        = s_q;
                        s_address_d = i_q;
                        s_data_d    = s_q;
                        s_wren_d    = 1'b1;
                    end
                    4'd5: begin
                        s_address_d = j_q;
                        s_data_d    = si_q;
                        s_wren_d    = 1'b1;
                    end
                    4'd6: s_address_d = sum_idx;
                    4'd8: begin
                        decrypt_address_d = k_q[AW-1:0];
                        decrypt_data_d    = decrypted;
                        decrypt_wren_d    = 1'b1;
                        k_d               = k_q + 9'd1;
                        phase_d           = '0;
`ifdef RC4_EARLY_ABORT_EN
                        if (!byte_valid) begin
                            state_d = NEXT_KEY;
                        end else if (last_byte) begin
                            k_d     = '0;
                            state_d = CHECK;
                        end
`else
                        if (last_byte) begin
                            k_d     = '0;
                            state_d = CHECK;
                        end
`endif
                    end
                    default: ;
                endcase
            end

            CHECK: begin
                phase_d = phase_q + 4'd1;
                case (phase_q)
                    4'd0: decrypt_address_d = k_q[AW-1:0];
                    4'd2: begin
                        phase_d = '0;
                        k_d     = k_q + 9'd1;
                        if (!byte_valid) begin
                            state_d = NEXT_KEY;
                        end else if (last_byte) begin
                            found_d = 1'b1;
                            busy_d  = 1'b0;
                            state_d = DONE;
                        end
                    end
                    default: ;
                endcase
            end

            NEXT_KEY: begin
                if (key_over) begin
                    not_found_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end else begin
                    key_d   = key_next[KEY_BITS-1:0];
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    kidx_d  = '0;
                    phase_d = '0;
                    state_d = INIT;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            phase_q           <= '0;
            i_q               <= '0;
            j_q               <= '0;
            k_q               <= '0;
            kidx_q            <= '0;
            si_q              <= '0;
            sj_q              <= '0;
            rom_byte_q        <= '0;
            key_q             <= '0;
            key_last_q        <= '0;
            busy_q            <= 1'b0;
            found_q           <= 1'b0;
            not_found_q       <= 1'b0;
            s_address_q       <= '0;
            s_data_q          <= '0;
            s_wren_q          <= 1'b0;
            rom_address_q     <= '0;
            decrypt_address_q <= '0;
            decrypt_data_q    <= '0;
            decrypt_wren_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            phase_q           <= phase_d;
            i_q               <= i_d;
            j_q               <= j_d;
            k_q               <= k_d;
            kidx_q            <= kidx_d;
            si_q              <= si_d;
            sj_q              <= sj_d;
            rom_byte_q        <= rom_byte_d;
            key_q             <= key_d;
            key_last_q        <= key_last_d;
            busy_q            <= busy_d;
            found_q           <= found_d;
            not_found_q       <= not_found_d;
            s_address_q       <= s_address_d;
            s_data_q          <= s_data_d;
            s_wren_q          <= s_wren_d;
            rom_address_q     <= rom_address_d;
            decrypt_address_q <= decrypt_address_d;
            decrypt_data_q    <= decrypt_data_d;
            decrypt_wren_q    <= decrypt_wren_d;
        end
    end

    assign busy            = busy_q;
    assign found           = found_q;
    assign not_found       = not_found_q;
    assign display_key     = key_q;
    assign s_address       = s_address_q;
    assign s_data          = s_data_q;
    assign s_wren          = s_wren_q;
    assign rom_address     = rom_address_q;
    assign decrypt_address = decrypt_address_q;
    assign decrypt_data    = decrypt_data_q;
    assign decrypt_wren    = decrypt_wren_q;

endmodule

// File: tb/tb_rc4_key_search.sv
// Table-driven bench for rc4_key_search with behavioural RAM/ROM models and
// an RC4 reference used only to build ciphertext images.
module tb_rc4_key_search;

    localparam int ROM_GOOD   = 0;
    localparam int ROM_ZERO   = 1;
    localparam int ROM_BAD_HI = 2;
    localparam int ROM_BAD_LO = 3;
    localparam logic [23:0] SECRET = 24'h000003;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [23:0] key_first;
    logic [23:0] key_last;
    logic        busy, found, not_found;
    logic [23:0] display_key;
    logic [7:0]  s_address, s_data, s_q;
    logic        s_wren;
    logic [4:0]  rom_address;
    logic [7:0]  rom_q;
    logic [4:0]  decrypt_address;
    logic [7:0]  decrypt_data, decrypt_q;
    logic        decrypt_wren;

    logic [7:0] sram [256];
    logic [7:0] rom  [32];
    logic [7:0] dram [32];

    int total = 0;
    int bad   = 0;
    int attempts = 0;
    int nonzero_writes = 0;
    int both_high = 0;
    int wren_idle = 0;

    typedef struct {
        logic [23:0] key_first;
        logic [23:0] key_last;
        int          rom_mode;
        logic        exp_found;
        logic        exp_not_found;
        logic [23:0] exp_key;
        int          exp_attempts;
        string       name;
    } vec_t;

    vec_t vecs [8];

    rc4_key_search dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .key_first       (key_first),
        .key_last        (key_last),
        .busy            (busy),
        .found           (found),
        .not_found       (not_found),
        .display_key     (display_key),
        .s_address       (s_address),
        .s_data          (s_data),
        .s_wren          (s_wren),
        .s_q             (s_q),
        .rom_address     (rom_address),
        .rom_q           (rom_q),
        .decrypt_address (decrypt_address),
        .decrypt_data    (decrypt_data),
        .decrypt_wren    (decrypt_wren),
        .decrypt_q       (decrypt_q)
    );

    always #5 clock = ~clock;

    // Synchronous-read memories: q follows the address one clock later.
    always @(posedge clock) begin
        if (s_wren) sram[s_address] <= s_data;
        s_q <= sram[s_address];
        rom_q <= rom[rom_address];
        if (decrypt_wren) dram[decrypt_address] <= decrypt_data;
        decrypt_q <= dram[decrypt_address];
    end

    always @(negedge clock) begin
        if (decrypt_wren && decrypt_address == 5'd0) attempts++;
        if (decrypt_wren && decrypt_address != 5'd0) nonzero_writes++;
        if (found && not_found) both_high++;
        if (!busy && (s_wren || decrypt_wren)) wren_idle++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rc4Keystream(input logic [23:0] key, output logic [7:0] ks [32]);
        logic [7:0] s [256];
        logic [7:0] i, j, t, kb;
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            case (n % 3)
                0: kb = key[23:16];
                1: kb = key[15:8];
                default: kb = key[7:0];
            endcase
            j = j + s[n] + kb;
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        for (int n = 0; n < 32; n++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            ks[n] = s[t];
        end
    endtask

    // Plaintext mixes letters (including 'a' and 'z') with spaces.
    task automatic loadRom(input int mode);
        logic [7:0] ks [32];
        logic [7:0] pt [32];
        rc4Keystream(SECRET, ks);
        for (int k = 0; k < 32; k++) pt[k] = (k % 7 == 6) ? 8'h20 : 8'(8'h61 + k % 26);
        if (mode == ROM_BAD_HI) pt[5] = 8'h7B;
        if (mode == ROM_BAD_LO) pt[31] = 8'h60;
        for (int k = 0; k < 32; k++) rom[k] = (mode == ROM_ZERO) ? 8'h00 : (pt[k] ^ ks[k]);
    endtask

    task automatic pulseStart(input logic [23:0] first, input logic [23:0] last);
        @(negedge clock);
        key_first = first;
        key_last  = last;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic waitDone(input string name, output int cycles);
        logic done;
        done   = 1'b0;
        cycles = 0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clock);
            cycles++;
            if (!busy) done = 1'b1;
        end
        checkOutput({name, ".timeout"}, {63'd0, ~done}, 64'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int cycles;
        loadRom(v.rom_mode);
        attempts = 0;
        pulseStart(v.key_first, v.key_last);
        waitDone(v.name, cycles);
        checkOutput({v.name, ".found"},     {63'd0, found},     {63'd0, v.exp_found});
        checkOutput({v.name, ".not_found"}, {63'd0, not_found}, {63'd0, v.exp_not_found});
        checkOutput({v.name, ".key"},       {40'd0, display_key}, {40'd0, v.exp_key});
        checkOutput({v.name, ".busy"},      {63'd0, busy},      64'd0);
        checkOutput({v.name, ".attempts"},  64'(attempts),      64'(v.exp_attempts));
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        vecs[0] = '{24'h000000, 24'h0000FF, ROM_GOOD,   1'b1, 1'b0, 24'h000003, 4, "scan_0_ff"};
        vecs[1] = '{24'h000003, 24'h000003, ROM_GOOD,   1'b1, 1'b0, 24'h000003, 1, "exact_key"};
        vecs[2] = '{24'h000000, 24'h000002, ROM_ZERO,   1'b0, 1'b1, 24'h000002, 3, "zero_rom"};
        vecs[3] = '{24'hFFFFFE, 24'hFFFFFF, ROM_ZERO,   1'b0, 1'b1, 24'hFFFFFF, 2, "no_wrap"};
        vecs[4] = '{24'h000005, 24'h000001, ROM_ZERO,   1'b0, 1'b1, 24'h000005, 1, "first_gt_last"};
        vecs[5] = '{24'h000003, 24'h000000, ROM_GOOD,   1'b1, 1'b0, 24'h000003, 1, "first_gt_last_hit"};
        vecs[6] = '{24'h000003, 24'h000003, ROM_BAD_HI, 1'b0, 1'b1, 24'h000003, 1, "byte_7b"};
        vecs[7] = '{24'h000003, 24'h000003, ROM_BAD_LO, 1'b0, 1'b1, 24'h000003, 1, "byte_60"};

        reset_n   = 1'b0;
        start     = 1'b0;
        key_first = '0;
        key_last  = '0;
        for (int k = 0; k < 32; k++) begin
            rom[k]  = 8'h00;
            dram[k] = 8'h00;
        end
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        repeat (100) @(negedge clock);
        checkOutput("idle.busy",         {63'd0, busy},         64'd0);
        checkOutput("idle.s_wren",       {63'd0, s_wren},       64'd0);
        checkOutput("idle.decrypt_wren", {63'd0, decrypt_wren}, 64'd0);
        checkOutput("idle.found",        {63'd0, found},        64'd0);
        checkOutput("idle.not_found",    {63'd0, not_found},    64'd0);

        for (int n = 0; n < 8; n++) applyStimulus(vecs[n]);

        $display("[TB] start while busy");
        loadRom(ROM_GOOD);
        pulseStart(24'h000003, 24'h000003);
        repeat (200) @(negedge clock);
        pulseStart(24'h000000, 24'h000000);
        waitDone("busy_start", cycles);
        checkOutput("busy_start.found", {63'd0, found},       64'd1);
        checkOutput("busy_start.key",   {40'd0, display_key}, 64'h3);

        $display("[TB] reset mid-KSA");
        pulseStart(24'h000001, 24'h0000FF);
        repeat (600) @(negedge clock);
        checkOutput("pre_reset.busy", {63'd0, busy},         64'd1);
        checkOutput("pre_reset.key",  {40'd0, display_key},  64'h1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset.busy",      {63'd0, busy},           64'd0);
        checkOutput("reset.s_wren",    {63'd0, s_wren},         64'd0);
        checkOutput("reset.s_address", {56'd0, s_address},      64'd0);
        checkOutput("reset.s_data",    {56'd0, s_data},         64'd0);
        checkOutput("reset.key",       {40'd0, display_key},    64'd0);
        checkOutput("reset.flags",     {62'd0, found, not_found}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        attempts = 0;
        pulseStart(24'h000003, 24'h000003);
        waitDone("after_reset", cycles);
        checkOutput("after_reset.found",    {63'd0, found},       64'd1);
        checkOutput("after_reset.key",      {40'd0, display_key}, 64'h3);
        checkOutput("after_reset.attempts", 64'(attempts),        64'd1);

`ifdef RC4_EARLY_ABORT_EN
        begin
            logic [7:0] ks0 [32];
            $display("[TB] early abort");
            rc4Keystream(24'h000000, ks0);
            for (int k = 0; k < 32; k++) rom[k] = 8'h00;
            rom[0] = ks0[0];
            nonzero_writes = 0;
            pulseStart(24'h000000, 24'h000000);
            waitDone("early_abort", cycles);
            checkOutput("early_abort.not_found",  {63'd0, not_found}, 64'd1);
            checkOutput("early_abort.writes_k1+", 64'(nonzero_writes), 64'd0);
            checkOutput("early_abort.fast",       64'(cycles < 2080), 64'd1);
        end
`endif

        checkOutput("never_both_flags", 64'(both_high), 64'd0);
        checkOutput("no_wren_idle",     64'(wren_idle), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
